// File: rtl/stall_control_unit.sv
// Stall/flush control for a 5-stage pipeline with a multi-cycle multdiv unit.
// Handles load-use hazards, taken-branch flushes, and multdiv start/wait/timeout.
module stall_control_unit #(
  parameter logic [5:0] MD_TIMEOUT = 6'd40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] FD_Latch_Instr,
  input  logic [31:0] DX_Latch_Instr,
  input  logic        branch_taken,
  input  logic        md_result_ready,
  output logic        stall_PC,
  output logic        stall_FD,
  output logic        stall_DX,
  output logic        nop_DX,
  output logic        nop_XM,
  output logic        flush_FD,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic        md_busy,
  output logic        md_timeout
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  localparam logic [4:0] OpRtype = 5'd0;
  localparam logic [4:0] OpBne   = 5'd2;
  localparam logic [4:0] OpJr    = 5'd4;
  localparam logic [4:0] OpAddi  = 5'd5;
  localparam logic [4:0] OpBlt   = 5'd6;
  localparam logic [4:0] OpSw    = 5'd7;
  localparam logic [4:0] OpLw    = 5'd8;
  localparam logic [4:0] OpBex   = 5'd22;
  localparam logic [4:0] AluMul  = 5'd6;
  localparam logic [4:0] AluDiv  = 5'd7;

  // Last BUSY count before the operation is declared hung.
  localparam logic [5:0] CntLast = MD_TIMEOUT - 6'd1;

  logic [0:0] state_q, state_d;
  logic [5:0] md_cnt_q, md_cnt_d;
  logic       md_timeout_q, md_timeout_d;

  // Field extraction
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  assign fd_op  = FD_Latch_Instr[31:27];
  assign fd_rd  = FD_Latch_Instr[26:22];
  assign fd_rs  = FD_Latch_Instr[21:17];
  assign fd_rt  = FD_Latch_Instr[16:12];
  assign dx_op  = DX_Latch_Instr[31:27];
  assign dx_rd  = DX_Latch_Instr[26:22];
  assign dx_alu = DX_Latch_Instr[6:2];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{FD_Latch_Instr[11:0], DX_Latch_Instr[21:7], DX_Latch_Instr[1:0]};

  logic dx_is_mul, dx_is_div, dx_is_lw;
  assign dx_is_mul = (dx_op == OpRtype) && (dx_alu == AluMul);
  assign dx_is_div = (dx_op == OpRtype) && (dx_alu == AluDiv);
  assign dx_is_lw  = (dx_op == OpLw);

  // Source registers read by the instruction in F/D (sw data register rd is not a hazard here)
  logic [4:0] src_a, src_b;
  logic       src_a_vld, src_b_vld;
  always_comb begin
    src_a     = 5'd0;
    src_b     = 5'd0;
    src_a_vld = 1'b0;
    src_b_vld = 1'b0;
    unique case (fd_op)
      OpRtype: begin
        src_a = fd_rs; src_a_vld = 1'b1;
        src_b = fd_rt; src_b_vld = 1'b1;
      end
      OpAddi, OpLw, OpSw: begin
        src_a = fd_rs; src_a_vld = 1'b1;
      end
      OpBne, OpBlt: begin
        src_a = fd_rd; src_a_vld = 1'b1;
        src_b = fd_rs; src_b_vld = 1'b1;
      end
      OpJr: begin
        src_a = fd_rd; src_a_vld = 1'b1;
      end
      OpBex: begin
        src_a = 5'd30; src_a_vld = 1'b1;
      end
      default: ;
    endcase
  end

  logic load_use;
  assign load_use = dx_is_lw && (dx_rd != 5'd0) &&
                    ((src_a_vld && (src_a == dx_rd)) || (src_b_vld && (src_b == dx_rd)));

  // Priority decode: BUSY handling, then branch flush, then multdiv start, then load-use
  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    md_timeout_d = md_timeout_q;
    stall_PC     = 1'b0;
    stall_FD     = 1'b0;
    stall_DX     = 1'b0;
    nop_DX       = 1'b0;
    nop_XM       = 1'b0;
    flush_FD     = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    if (reset) begin
      state_d = StIdle;
    end else if (state_q == StBusy) begin
      if (md_result_ready) begin
        state_d = StIdle;
      end else if (md_cnt_q >= CntLast) begin
        // Let DX move on but keep the missing result out of X/M.
        md_timeout_d = 1'b1;
        nop_XM       = 1'b1;
        state_d      = StIdle;
      end else begin
        stall_PC = 1'b1;
        stall_FD = 1'b1;
        stall_DX = 1'b1;
        nop_XM   = 1'b1;
        md_cnt_d = md_cnt_q + 6'd1;
      end
    end else if (branch_taken) begin
      flush_FD = 1'b1;
      nop_DX   = 1'b1;
    end else if (dx_is_mul || dx_is_div) begin
      md_ctrl_MULT = dx_is_mul;
      md_ctrl_DIV  = dx_is_div;
      stall_PC     = 1'b1;
      stall_FD     = 1'b1;
      stall_DX     = 1'b1;
      nop_XM       = 1'b1;
      state_d      = StBusy;
      md_cnt_d     = 6'd0;
    end else if (load_use) begin
      stall_PC = 1'b1;
      stall_FD = 1'b1;
      nop_DX   = 1'b1;
    end
  end

  assign md_busy    = !reset && (state_q == StBusy);
  assign md_timeout = md_timeout_q;

  // State, counter and sticky timeout flag with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      md_cnt_q     <= 6'd0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      md_timeout_q <= md_timeout_d;
    end
  end

endmodule

// File: doc/stall_control_unit.md
STALL_CONTROL_UNIT -- requirements
Module: stall_control_unit

Interface
REQ-001 The module SHALL have one parameter: MD_TIMEOUT, default 6'd40, the maximum BUSY cycles allowed for a multdiv operation.
REQ-002 The module SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clock  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous, active-high.
REQ-005 Port: FD_Latch_Instr  input  32  instruction in F/D latch.
REQ-006 Port: DX_Latch_Instr  input  32  instruction in D/X latch.
REQ-007 Port: branch_taken  input  1  taken branch/jump resolved in X this cycle.
REQ-008 Port: md_result_ready  input  1  multdiv result valid.
REQ-009 Port: stall_PC, stall_FD, stall_DX  output  1 each  hold the PC, F/D latch and D/X latch this cycle.
REQ-010 Port: nop_DX, nop_XM, flush_FD  output  1 each  load a nop into D/X, X/M or F/D at the next edge.
REQ-011 Port: md_ctrl_MULT, md_ctrl_DIV  output  1 each  one-cycle multdiv start pulses.
REQ-012 Port: md_busy  output  1  state==BUSY.
REQ-013 Port: md_timeout  output  1  sticky timeout error flag.

Function
REQ-014 Decode SHALL use fields opcode[31:27], rd[26:22], rs[21:17], rt[16:12], ALU_op[6:2]; mul is opcode 0 with ALU_op 6, div is opcode 0 with ALU_op 7, lw is opcode 8.
REQ-015 FD source registers SHALL be:
  - R-type (op 0): rs, rt.
  - addi (5), lw (8): rs.
  - sw (7): rs only.
  - bne (2), blt (6): rd, rs.
  - jr (4): rd.
  - bex (22): r30.
  - all other opcodes: none.
REQ-016 load_use SHALL be 1 when DX is lw, DX rd!=0, and DX rd equals any FD source register.
REQ-017 The FSM SHALL have states IDLE and BUSY and a 6-bit counter md_cnt.
REQ-018 IDLE behaviour, when DX is mul/div and branch_taken=0:
  - md_ctrl_MULT or md_ctrl_DIV=1 for this cycle only.
  - stall_PC=stall_FD=stall_DX=nop_XM=1.
  - next state BUSY, md_cnt<=0.
  - md_result_ready is ignored in IDLE.
REQ-019 BUSY with md_result_ready=0 and md_cnt<MD_TIMEOUT-1:
  - stall_PC=stall_FD=stall_DX=nop_XM=1.
  - md_cnt increments.
  - no ctrl pulse.
REQ-020 BUSY with md_result_ready=1: all stalls and nop_XM SHALL be 0 in that same cycle so the result advances to X/M, and next state is IDLE.
REQ-021 BUSY with md_result_ready=0 and md_cnt==MD_TIMEOUT-1:
  - md_timeout<=1 (sticky until reset).
  - stall_PC=stall_FD=stall_DX=0 and nop_XM=1, so DX advances and a nop, not a garbage result, enters X/M.
  - next state IDLE.
  - md_result_ready=1 in this cycle takes priority over timeout.
REQ-022 Load-use, IDLE only, no branch_taken, DX not mul/div: stall_PC=stall_FD=nop_DX=1 for one cycle.
REQ-023 branch_taken SHALL force flush_FD=nop_DX=1 and override load-use stalls and the IDLE mul/div start (no ctrl pulse, state stays IDLE).
REQ-024 Priority SHALL be: BUSY handling > branch_taken > mul/div start > load_use.
REQ-025 md_ctrl_MULT and md_ctrl_DIV SHALL never be asserted together, and SHALL never be asserted in consecutive cycles for the same DX instruction.
REQ-026 All stall/nop/flush/ctrl outputs SHALL be combinational from state, md_cnt and the inputs; state, md_cnt and md_timeout SHALL be registered.

Reset
REQ-027 While reset=1: next state IDLE, md_cnt=0, md_timeout=0.
REQ-028 While reset=1, all combinational outputs SHALL be forced to 0, including during a mid-BUSY reset.
REQ-029 After reset deasserts, an in-flight multdiv SHALL be abandoned with no pulse replayed until a fresh IDLE evaluation.

Verification
REQ-030 DX=lw r5; FD=add r6,r5,r2 -> stall_PC=stall_FD=nop_DX=1 for exactly one cycle. Repeat with DX lw r0 -> no stall.
REQ-031 DX=lw r5; FD=sw r5,0(r7) (r5 as data only) -> no stall. FD=sw r7,0(r5) -> stall.
REQ-032 DX=mul; md_result_ready rises after 17 cycles ->
  - md_ctrl_MULT pulses in cycle 0 only.
  - md_busy=1 for cycles 1..17.
  - stalls are released in the ready cycle.
  - no second pulse.
REQ-033 MD_TIMEOUT=8, DX=div, ready never asserted ->
  - md_timeout=1 after cycle 8.
  - nop_XM=1 and stalls low in the timeout cycle.
  - FSM returns to IDLE.
REQ-034 branch_taken=1 with FD=lw-dependent consumer -> flush_FD=nop_DX=1 and stall_PC=0. branch_taken=1 with DX=mul in IDLE -> no ctrl pulse.
REQ-035 Reset asserted in the 3rd BUSY cycle -> all outputs 0 next cycle, md_busy=0, md_timeout cleared.
